spi_master_ctrl: RTL and testbench

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_clk_div.sv | 35 +++
 rtl/spi_master_ctrl.sv | 134 +++++++++++++
 tb/tb_spi_master_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI constants: FSM encoding, default half-period and mode bits.
// Used by both the SPI master and the SPI slave.
package spi_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_SCK_HI = 3'd2;
    localparam logic [2:0] ST_SCK_LO = 3'd3;
    localparam logic [2:0] ST_GAP    = 3'd4;

    localparam int unsigned CLK_DIV_DEFAULT = 4;
    localparam int unsigned DIV_CNT_W       = 8;

    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer: reload on load_i, count down, tick_o when the
// current phase has lasted DIV cycles.
module spi_clk_div #(
    parameter int unsigned DIV = 4,
    parameter int unsigned W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic tick_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(DIV - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master, MSB first, with optional chip-select hold for bursts.
// All outputs come straight from registers.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT,
    parameter int unsigned DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              keep_ss,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              spi_ss,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int unsigned BW = $clog2(DATA_W + 1);

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [DATA_W-1:0] tx_sh_q;
    logic [DATA_W-1:0] rx_sh_q;
    logic [DATA_W-1:0] rx_q;
    logic [BW-1:0]     bit_cnt_q;
    logic              keep_q;
    logic              ss_q;
    logic              sck_q;
    logic              mosi_q;
    logic              done_q;

    logic tick;
    logic load;
    logic last_bit;
    logic accept;
    logic enter_hi;
    logic enter_lo;
    logic enter_gap;
    logic enter_idle;

    // bit_cnt_q advances on each SCK_LO entry, so it reads DATA_W in the last one
    assign last_bit = (bit_cnt_q == BW'(DATA_W));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_SETUP;
            ST_SETUP:  if (tick)  state_d = ST_SCK_HI;
            ST_SCK_HI: if (tick)  state_d = ST_SCK_LO;
            ST_SCK_LO: begin
                if (tick) begin
                    if (!last_bit)   state_d = ST_SCK_HI;
                    else if (keep_q) state_d = ST_IDLE;
                    else             state_d = ST_GAP;
                end
            end
            ST_GAP:    if (tick)  state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    assign load       = (state_d != state_q);
    assign accept     = (state_q == ST_IDLE) && start;
    assign enter_hi   = load && (state_d == ST_SCK_HI);
    assign enter_lo   = load && (state_d == ST_SCK_LO);
    assign enter_gap  = load && (state_d == ST_GAP);
    assign enter_idle = load && (state_d == ST_IDLE);

    spi_clk_div #(
        .DIV (CLK_DIV),
        .W   (DIV_CNT_W)
    ) u_clk_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .tick_o (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_q      <= '0;
            bit_cnt_q <= '0;
            keep_q    <= 1'b0;
            ss_q      <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            if (accept) begin
                tx_sh_q   <= tx_data;
                keep_q    <= keep_ss;
                ss_q      <= 1'b0;
                mosi_q    <= tx_data[DATA_W-1];
                bit_cnt_q <= '0;
            end
            if (enter_hi) begin
                sck_q   <= 1'b1;
                rx_sh_q <= {rx_sh_q[DATA_W-2:0], spi_miso};
            end
            if (enter_lo) begin
                sck_q     <= 1'b0;
                tx_sh_q   <= {tx_sh_q[DATA_W-2:0], 1'b0};
                mosi_q    <= tx_sh_q[DATA_W-2];
                bit_cnt_q <= bit_cnt_q + BW'(1);
            end
            if (enter_gap) begin
                ss_q   <= 1'b1;
                mosi_q <= 1'b0;
            end
            if (enter_idle) begin
                done_q <= 1'b1;
                rx_q   <= rx_sh_q;
            end
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign rx_data  = rx_q;
    assign spi_ss   = ss_q;
    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: CLK_DIV=2 instance for function,
// CLK_DIV=255 instance for long half-period timing.
module tb_spi_master_ctrl;

    typedef struct {
        logic [7:0] rx;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    logic       rst_a, start_a, keep_a, sel_a;
    logic [7:0] tx_a;
    logic       busy_a, done_a, ss_a, sck_a, mosi_a, miso_a;
    logic [7:0] rx_a;

    logic       rst_b, start_b, keep_b;
    logic [7:0] tx_b;
    logic       busy_b, done_b, ss_b, sck_b, mosi_b, miso_b;
    logic [7:0] rx_b;

    logic [7:0] slv_tx = 8'h00;
    logic [7:0] slv_rx = 8'h00;
    logic       slv_sck_q = 1'b0;

    assign miso_a = sel_a ? slv_tx[7] : mosi_a;
    assign miso_b = mosi_b;

    spi_master_ctrl #(.CLK_DIV(2), .DATA_W(8)) u_a (
        .clk      (clk),
        .rst_n    (rst_a),
        .start    (start_a),
        .tx_data  (tx_a),
        .keep_ss  (keep_a),
        .busy     (busy_a),
        .done     (done_a),
        .rx_data  (rx_a),
        .spi_ss   (ss_a),
        .spi_sck  (sck_a),
        .spi_mosi (mosi_a),
        .spi_miso (miso_a)
    );

    spi_master_ctrl #(.CLK_DIV(255), .DATA_W(8)) u_b (
        .clk      (clk),
        .rst_n    (rst_b),
        .start    (start_b),
        .tx_data  (tx_b),
        .keep_ss  (keep_b),
        .busy     (busy_b),
        .done     (done_b),
        .rx_data  (rx_b),
        .spi_ss   (ss_b),
        .spi_sck  (sck_b),
        .spi_mosi (mosi_b),
        .spi_miso (miso_b)
    );

    // Mode-0 slave: sample MOSI after SCK rises, shift MISO after SCK falls
    always @(posedge clk) begin
        slv_sck_q <= sck_a;
        if (ss_a)
            slv_tx <= 8'h3C;
        else if (slv_sck_q && !sck_a)
            slv_tx <= {slv_tx[6:0], 1'b0};
        if (!slv_sck_q && sck_a)
            slv_rx <= {slv_rx[6:0], mosi_a};
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    exp_t qa[$];
    exp_t qb[$];

    int   rises_a = 0;
    int   dones_a = 0;
    int   viol_a  = 0;
    int   ss_hi_a = 0;
    logic burst_win = 1'b0;
    logic sck_a_p = 1'b0;
    logic mosi_a_p = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (done_a === 1'b1) begin
            dones_a++;
            if (qa.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL a_done_unexpected: done at cycle %0d, want none",
                         cyc);
            end else begin
                e = qa.pop_front();
                chk("a_rx_data", {24'h0, rx_a}, {24'h0, e.rx});
                chk("a_done_cycle", cyc, e.cyc);
            end
        end
        if (sck_a && !sck_a_p) rises_a++;
        if ((mosi_a !== mosi_a_p) && sck_a) viol_a++;
        if (burst_win && ss_a) ss_hi_a++;
        sck_a_p  = sck_a;
        mosi_a_p = mosi_a;
    end

    int   hi_b = 0;
    int   lo_b = 0;
    int   perr_b = 0;
    int   run_b = 0;
    logic sck_b_p = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (done_b === 1'b1) begin
            if (qb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL b_done_unexpected: done at cycle %0d, want none",
                         cyc);
            end else begin
                e = qb.pop_front();
                chk("b_rx_data", {24'h0, rx_b}, {24'h0, e.rx});
                chk("b_done_cycle", cyc, e.cyc);
            end
        end
        if (sck_b === sck_b_p) begin
            run_b++;
        end else begin
            if (sck_b_p) begin
                hi_b++;
                if (run_b != 255) perr_b++;
            end else if (hi_b > 0) begin
                lo_b++;
                if (run_b != 255) perr_b++;
            end
            run_b = 1;
        end
        sck_b_p = sck_b;
    end

    int ta = 0;
    int tb0 = 0;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) tick();
    endtask

    task automatic go_a(input logic [7:0] tx, input logic keep,
                        input logic [7:0] rx, input int lat,
                        input bit push);
        exp_t e;
        start_a = 1'b1;
        tx_a    = tx;
        keep_a  = keep;
        ta      = cyc;
        e.rx    = rx;
        e.cyc   = cyc + lat;
        if (push) qa.push_back(e);
        tick();
        start_a = 1'b0;
    endtask

    int r0, d0, s0, v0;

    initial begin
        exp_t eb;
        rst_a = 1'b0; start_a = 1'b0; keep_a = 1'b0; tx_a = '0; sel_a = 1'b0;
        rst_b = 1'b0; start_b = 1'b0; keep_b = 1'b0; tx_b = '0;
        tick();
        tick();
        chk("rst_busy", {31'h0, busy_a}, 0);
        chk("rst_done", {31'h0, done_a}, 0);
        chk("rst_ss", {31'h0, ss_a}, 1);
        chk("rst_sck", {31'h0, sck_a}, 0);
        chk("rst_mosi", {31'h0, mosi_a}, 0);
        chk("rst_rx", {24'h0, rx_a}, 0);
        chk("rst_b_ss", {31'h0, ss_b}, 1);
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();
        tick();

        // CLK_DIV=255 loopback of 0xFF
        start_b = 1'b1; tx_b = 8'hFF; keep_b = 1'b0;
        tb0 = cyc;
        eb.rx = 8'hFF;
        eb.cyc = cyc + 18 * 255 + 1;
        qb.push_back(eb);
        tick();
        start_b = 1'b0;
        wait_cyc(tb0 + 18 * 255 + 4);
        chk("b_hi_phases", hi_b, 8);
        chk("b_lo_phases", lo_b, 7);
        chk("b_phase_len_err", perr_b, 0);
        chk("b_busy_after", {31'h0, busy_b}, 0);

        // loopback 0xA5, keep_ss=0
        r0 = rises_a;
        go_a(8'hA5, 1'b0, 8'hA5, 37, 1'b1);
        chk("lb_busy", {31'h0, busy_a}, 1);
        chk("lb_ss_low", {31'h0, ss_a}, 0);
        wait_cyc(ta + 34);
        chk("lb_ss_before_gap", {31'h0, ss_a}, 0);
        tick();
        chk("lb_ss_gap", {31'h0, ss_a}, 1);
        chk("lb_mosi_gap", {31'h0, mosi_a}, 0);
        chk("lb_busy_gap", {31'h0, busy_a}, 1);
        wait_cyc(ta + 38);
        chk("lb_sck_rises", rises_a - r0, 8);
        chk("lb_busy_end", {31'h0, busy_a}, 0);

        // start pulses while busy are ignored
        r0 = rises_a;
        go_a(8'h96, 1'b0, 8'h96, 37, 1'b1);
        wait_cyc(ta + 3);
        start_a = 1'b1; tx_a = 8'hFF; keep_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_cyc(ta + 10);
        start_a = 1'b1; tx_a = 8'h00; keep_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_cyc(ta + 40);
        chk("ign_sck_rises", rises_a - r0, 8);
        chk("ign_busy_end", {31'h0, busy_a}, 0);

        // slave model returns 0x3C while master sends 0xC3
        sel_a = 1'b1;
        v0 = viol_a;
        go_a(8'hC3, 1'b0, 8'h3C, 37, 1'b1);
        wait_cyc(ta + 40);
        chk("slv_captured", {24'h0, slv_rx}, 32'hC3);
        chk("slv_mosi_edge", viol_a - v0, 0);
        sel_a = 1'b0;

        // burst 01,02,03 with chip select held, each start in the done cycle
        d0 = dones_a;
        s0 = ss_hi_a;
        go_a(8'h01, 1'b1, 8'h01, 35, 1'b1);
        burst_win = 1'b1;
        wait_cyc(ta + 35);
        go_a(8'h02, 1'b1, 8'h02, 35, 1'b1);
        wait_cyc(ta + 35);
        go_a(8'h03, 1'b0, 8'h03, 37, 1'b1);
        wait_cyc(ta + 34);
        burst_win = 1'b0;
        chk("burst_ss_held", ss_hi_a - s0, 0);
        tick();
        chk("burst_ss_rise", {31'h0, ss_a}, 1);
        wait_cyc(ta + 40);
        chk("burst_dones", dones_a - d0, 3);

        // reset after the 4th SCK rise aborts the transfer
        r0 = rises_a;
        go_a(8'hE7, 1'b0, 8'hE7, 37, 1'b0);
        while ((rises_a - r0) < 4 && cyc < ta + 100) tick();
        chk("rst_mid_rises", rises_a - r0, 4);
        #2;
        rst_a = 1'b0;
        #1;
        chk("abort_ss", {31'h0, ss_a}, 1);
        chk("abort_sck", {31'h0, sck_a}, 0);
        chk("abort_busy", {31'h0, busy_a}, 0);
        chk("abort_rx", {24'h0, rx_a}, 0);
        tick();
        tick();
        rst_a = 1'b1;
        tick();
        d0 = dones_a;
        go_a(8'h5A, 1'b0, 8'h5A, 37, 1'b1);
        wait_cyc(ta + 40);
        chk("post_rst_dones", dones_a - d0, 1);

        tick();
        tick();
        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);
        chk("a_mosi_edge_total", viol_a, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
